// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: FSM states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // red_xor is the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic [1:0] mode, input logic red_xor);
    case (mode)
      PAR_ODD:  return ~red_xor;
      PAR_EVEN: return red_xor;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Input word stream of the UART transmitter.
// A word moves on a clk edge where s_valid && s_ready; s_valid may stay high while s_ready is low.
interface uart_tx_param_if #(
  parameter int DATA_W = 8
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  // A pop frees a slot in the same cycle, so a full FIFO may push and pop together.
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: baud enable, frame FSM and parity on one clock.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the frame FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_param_if.slave   s,
  input  logic [1:0]       parity_type,
  input  logic             stop2,
  input  logic [DIV_W-1:0] baud_div,
  output logic             data_tx,
  output logic             active_flag,
  output logic             done_flag,
  output tx_state_t        dbg_state
);
  localparam int IDX_W = 4;

  tx_state_t         state_q, state_d;
  logic [DIV_W-1:0]  bit_cnt_q, bit_cnt_d, div_q, div_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [1:0]        par_q, par_d;
  logic              stop2_q, stop2_d, par_bit_q, par_bit_d;
  logic              tx_q, active_q, done_q;
  logic              bit_tick, last_stop, take, line;
  logic [DATA_W-1:0] word;

  assign bit_tick  = (bit_cnt_q == div_q);
  assign last_stop = (state_q == STOP) && bit_tick &&
                     (bit_idx_q == {{(IDX_W-1){1'b0}}, stop2_q});

`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_tx_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s.s_valid && !fifo_full),
    .wdata_i (s.s_data),
    .pop_i   (take),
    .rdata_o (word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign s.s_ready = !fifo_full;
  assign take      = ((state_q == IDLE) || last_stop) && !fifo_empty;
`else
  // The shift register doubles as the holding register, so a word is only taken when it can start.
  assign s.s_ready = (state_q == IDLE) || last_stop;
  assign take      = s.s_valid && s.s_ready;
  assign word      = s.s_data;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    div_d     = div_q;
    par_bit_d = par_bit_q;
    line      = 1'b1;

    case (state_q)
      START:   line = 1'b0;
      DATA:    line = shreg_q[0];
      PARITY:  line = par_bit_q;
      default: line = 1'b1;
    endcase

    if (state_q != IDLE) bit_cnt_d = bit_tick ? '0 : bit_cnt_q + 1'b1;

    if (bit_tick) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d   = (par_q == PAR_NONE) ? STOP : PARITY;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        PARITY: begin
          state_d   = STOP;
          bit_idx_d = '0;
        end
        STOP: begin
          if (last_stop) state_d = IDLE;
          else           bit_idx_d = bit_idx_q + 1'b1;
        end
        default: ;
      endcase
    end

    // Configuration is frozen per frame at the moment the word is taken.
    if (take) begin
      state_d   = START;
      bit_cnt_d = '0;
      bit_idx_d = '0;
      shreg_d   = word;
      par_d     = parity_type;
      stop2_d   = stop2;
      div_d     = baud_div;
      par_bit_d = parity_bit(parity_type, ^word);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      div_q     <= div_d;
      par_bit_q <= par_bit_d;
      // Outputs are registered one cycle behind the FSM so the line is glitch-free.
      tx_q      <= line;
      active_q  <= (state_q != IDLE);
      done_q    <= last_stop;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: checks every line cycle against hand-built frames.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       parity_type;
  logic             stop2;
  logic [DIV_W-1:0] baud_div;
  logic             data_tx, active_flag, done_flag;
  tx_state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  uart_tx_param_if #(.DATA_W(DATA_W)) bus ();

  uart_tx_param #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (bus),
    .parity_type (parity_type),
    .stop2       (stop2),
    .baud_div    (baud_div),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_FIFO_EN
  bit   rec_en = 1'b0;
  logic line_q[$];
  logic [DATA_W-1:0] exp_q[$];

  always @(negedge clk) if (rec_en) line_q.push_back(data_tx);
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start bit, data LSB first, one stop bit; index i is the i-th bit on the line.
  function automatic logic [15:0] plain_bits(input logic [DATA_W-1:0] w);
    return {7'b0, 1'b1, w, 1'b0};
  endfunction

  task automatic accept(input logic [DATA_W-1:0] w);
    bus.s_data  = w;
    bus.s_valid = 1'b1;
    chk("ready_idle", bus.s_ready, 1'b1);
    tick();
    bus.s_valid = 1'b0;
    chk("latency_line", data_tx, 1'b1);
    chk("latency_state", dbg_state, START);
  endtask

  task automatic check_frame(input logic [15:0] bits, input int nbits, input int div,
                             input bit has_next, input logic [DATA_W-1:0] nxt,
                             input int chg_at, input logic [DIV_W-1:0] chg_div);
    int f;
    f = nbits * (div + 1);
    bus.s_valid = has_next;
    if (has_next) bus.s_data = nxt;
    for (int i = 0; i < f; i++) begin
      if (i == chg_at) baud_div = chg_div;
      tick();
      chk("line", data_tx, bits[i / (div + 1)]);
      chk("active", active_flag, 1'b1);
      chk("done", done_flag, (i == f - 1));
      chk("ready", bus.s_ready, (i == f - 2) || (i == f - 1 && !has_next));
    end
    if (!has_next) bus.s_valid = 1'b0;
  endtask

  task automatic idle_check();
    tick();
    chk("idle_active", active_flag, 1'b0);
    chk("idle_line", data_tx, 1'b1);
    chk("idle_done", done_flag, 1'b0);
    chk("idle_state", dbg_state, IDLE);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    parity_type = PAR_NONE;
    stop2       = 1'b0;
    baud_div    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_line", data_tx, 1'b1);
    chk("rst_active", active_flag, 1'b0);
    chk("rst_done", done_flag, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_ready", bus.s_ready, 1'b1);
    rst_n = 1'b1;
    tick();

`ifdef UART_TX_FIFO_EN
    // Nine pushes with the line busy: the first word is popped at once, eight fill the FIFO.
    baud_div = 16'd0;
    rec_en   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.s_data  = DATA_W'(8'h11 + i * 8'h1D);
      bus.s_valid = 1'b1;
      chk("fifo_ready", bus.s_ready, 1'b1);
      exp_q.push_back(bus.s_data);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("fifo_full", bus.s_ready, 1'b0);
    repeat (9 * 10 + 10) tick();
    rec_en = 1'b0;
    for (int k = 0; k < 40 && line_q.size() > 0 && line_q[0] == 1'b1; k++) void'(line_q.pop_front());
    for (int n = 0; n < 9; n++) begin
      logic [15:0] b;
      b = plain_bits(exp_q.pop_front());
      for (int j = 0; j < 10; j++) begin
        if (line_q.size() == 0) chk("fifo_underrun", 1'b0, 1'b1);
        else chk("fifo_bit", line_q.pop_front(), b[j]);
      end
    end
    idle_check();
`else
    // T1: even parity, 4 clks/bit, 0xA5 -> 0,1,0,1,0,0,1,0,1,0,1
    baud_div = 16'd3; parity_type = PAR_EVEN; stop2 = 1'b0;
    accept(8'hA5);
    check_frame(16'h054A, 11, 3, 1'b0, '0, -1, '0);
    idle_check();

    // T2: odd parity of 0x00 is 1, two stop bits
    parity_type = PAR_ODD; stop2 = 1'b1;
    accept(8'h00);
    check_frame(16'h0E00, 12, 3, 1'b0, '0, -1, '0);
    idle_check();

    // Mark parity, 2 clks/bit: 0x0F -> 0,1,1,1,1,0,0,0,0,1,1
    parity_type = PAR_MARK; stop2 = 1'b0; baud_div = 16'd1;
    accept(8'h0F);
    check_frame(16'h061E, 11, 1, 1'b0, '0, -1, '0);
    idle_check();

    // T3: no parity, one clk/bit, four words streamed back-to-back
    parity_type = PAR_NONE; stop2 = 1'b0; baud_div = 16'd0;
    accept(8'h3C);
    check_frame(plain_bits(8'h3C), 10, 0, 1'b1, 8'hFF, -1, '0);
    check_frame(plain_bits(8'hFF), 10, 0, 1'b1, 8'h81, -1, '0);
    check_frame(plain_bits(8'h81), 10, 0, 1'b1, 8'h5A, -1, '0);
    check_frame(plain_bits(8'h5A), 10, 0, 1'b0, '0, -1, '0);
    idle_check();

    // T6: baud_div 3 -> 7 mid-frame only affects the following frame
    baud_div = 16'd3;
    accept(8'h96);
    check_frame(plain_bits(8'h96), 10, 3, 1'b0, '0, 5, 16'd7);
    idle_check();
    accept(8'h69);
    check_frame(plain_bits(8'h69), 10, 7, 1'b0, '0, -1, '0);
    idle_check();

    // T5: asynchronous reset in the middle of the data bits
    baud_div = 16'd1;
    accept(8'hF0);
    tick(); tick(); tick();
    chk("t5_in_data", dbg_state, DATA);
    chk("t5_active", active_flag, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_line", data_tx, 1'b1);
    chk("t5_rst_active", active_flag, 1'b0);
    chk("t5_rst_done", done_flag, 1'b0);
    chk("t5_rst_state", dbg_state, IDLE);
    #1 rst_n = 1'b1;
    tick();
    // Clean frame after reset: 0x33, even parity 0, two stop bits
    parity_type = PAR_EVEN; stop2 = 1'b1;
    accept(8'h33);
    check_frame(16'h0C66, 12, 1, 1'b0, '0, -1, '0);
    idle_check();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
